// File: rtl/off_chip_rx_pkg.sv
// Shared types and default constants for the off-chip serial frame aligner.
package off_chip_rx_pkg;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  localparam int          FRAME_W_D      = 16;
  localparam logic [15:0] SYNC_WORD_D    = 16'hBC5A;
  localparam int          LOCK_CNT_D     = 3;
  localparam int          SYNC_TIMEOUT_D = 8;

endpackage

// File: rtl/off_chip_rx_shreg.sv
// Serial shift window plus frame-boundary counter; realign restarts the frame grid.
module off_chip_rx_shreg
  import off_chip_rx_pkg::*;
#(
  parameter int FRAME_W = FRAME_W_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               serin,
  input  logic               realign,
  output logic [FRAME_W-1:0] sreg,
  output logic               boundary
);

  localparam int BW = $clog2(FRAME_W + 1);

  logic [BW-1:0] bit_cnt;

  // bit_cnt counts bits shifted in since the last boundary, so a full frame sits in sreg
  assign boundary = (bit_cnt == BW'(FRAME_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      sreg <= {sreg[FRAME_W-2:0], serin};
      if (realign || boundary) bit_cnt <= BW'(1);
      else                     bit_cnt <= bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/off_chip_rx_aligner.sv
// Sync-word frame aligner: hunts, verifies over LOCK_CNT frames, then delivers payload
// frames until SYNC_TIMEOUT frames pass without a sync frame.
module off_chip_rx_aligner
  import off_chip_rx_pkg::*;
#(
  parameter int                 FRAME_W      = FRAME_W_D,
  parameter logic [FRAME_W-1:0] SYNC_WORD    = SYNC_WORD_D,
  parameter int                 LOCK_CNT     = LOCK_CNT_D,
  parameter int                 SYNC_TIMEOUT = SYNC_TIMEOUT_D
) (
  input  logic               clk160,
  input  logic               rst,
  input  logic               serin,
  output logic [FRAME_W-1:0] data_out,
  output logic               data_valid,
  output logic               locked,
  output logic [7:0]         lock_loss_cnt
);

  localparam int VW = $clog2(LOCK_CNT + 1);
  localparam int GW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [VW-1:0] VLAST = VW'(LOCK_CNT - 1);
  localparam logic [GW-1:0] GLAST = GW'(SYNC_TIMEOUT - 1);

  state_t             state;
  logic [VW-1:0]      vcnt;
  logic [GW-1:0]      gap;
  logic [FRAME_W-1:0] sreg;
  logic               boundary;
  logic               match;
  logic               realign;

  assign match   = (sreg == SYNC_WORD);
  assign realign = (state == HUNT) && match;

  off_chip_rx_shreg #(.FRAME_W(FRAME_W)) u_shreg (
    .clk      (clk160),
    .rst      (rst),
    .serin    (serin),
    .realign  (realign),
    .sreg     (sreg),
    .boundary (boundary)
  );

  always_ff @(posedge clk160) begin
    if (rst) begin
      state         <= HUNT;
      vcnt          <= '0;
      gap           <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      locked        <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        HUNT: begin
          if (match) begin
            state <= VERIFY;
            vcnt  <= VW'(1);
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (match) begin
              vcnt <= vcnt + VW'(1);
              if (vcnt == VLAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
                gap    <= '0;
              end
            end else begin
              state <= HUNT;
              vcnt  <= '0;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            // a sync frame on the timeout boundary takes priority and keeps lock
            if (match) begin
              gap <= '0;
            end else begin
              data_out   <= sreg;
              data_valid <= 1'b1;
              gap        <= gap + GW'(1);
              if (gap == GLAST) begin
                state  <= HUNT;
                locked <= 1'b0;
                if (lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
              end
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_off_chip_rx_aligner.sv
// Randomized bench for off_chip_rx_aligner against a frame-grid reference model.
module tb_off_chip_rx_aligner;

  localparam logic [15:0] SYNC = 16'hBC5A;
  localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

  logic        clk160 = 1'b0;
  logic        rst    = 1'b1;
  logic        serin  = 1'b0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        locked;
  logic [7:0]  lock_loss_cnt;

  off_chip_rx_aligner dut (
    .clk160        (clk160),
    .rst           (rst),
    .serin         (serin),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .locked        (locked),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk160 = ~clk160;

  int n_vec = 0;
  int n_err = 0;

  // reference model: frame grid is anchored at the edge that saw the sync match
  logic [15:0] m_win;
  int          m_mode, m_cyc, m_anchor, m_syncs, m_gap;
  logic [15:0] e_data;
  logic        e_valid, e_locked;
  logic [7:0]  e_loss;
  logic [15:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic b, input logic r);
    bit on_grid, is_sync;
    if (r) begin
      m_win = '0; m_mode = M_HUNT; m_syncs = 0; m_gap = 0;
      e_data = '0; e_valid = 1'b0; e_locked = 1'b0; e_loss = '0;
    end else begin
      e_valid = 1'b0;
      on_grid = (m_cyc > m_anchor) && ((m_cyc - m_anchor) % 16 == 0);
      is_sync = (m_win == SYNC);
      if (m_mode == M_HUNT) begin
        if (is_sync) begin m_mode = M_VERIFY; m_anchor = m_cyc; m_syncs = 1; end
      end else if (on_grid && m_mode == M_VERIFY) begin
        if (is_sync) begin
          m_syncs++;
          if (m_syncs == 3) begin m_mode = M_LOCKED; m_gap = 0; e_locked = 1'b1; end
        end else begin
          m_mode = M_HUNT; m_syncs = 0;
        end
      end else if (on_grid && m_mode == M_LOCKED) begin
        if (is_sync) m_gap = 0;
        else begin
          e_data = m_win; e_valid = 1'b1; m_gap++;
          if (m_gap == 8) begin
            m_mode = M_HUNT; e_locked = 1'b0;
            if (e_loss != 8'd255) e_loss++;
          end
        end
      end
      m_win = {m_win[14:0], b};
    end
    m_cyc++;
  endtask

  task automatic tick(input logic b, input logic r);
    serin = b;
    rst   = r;
    @(posedge clk160);
    model_edge(b, r);
    #1;
    chk("data_out", data_out, e_data);
    chk("data_valid", data_valid, e_valid);
    chk("locked", locked, e_locked);
    chk("lock_loss_cnt", lock_loss_cnt, e_loss);
    if (data_valid) got.push_back(data_out);
  endtask

  task automatic send_frame(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) tick(w[i], 1'b0);
  endtask

  task automatic rand_bits(input int n);
    for (int i = 0; i < n; i++) tick(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // low nibble forced to 0: never the sync word and never aliases a sync prefix
  function automatic logic [15:0] rand_data();
    logic [31:0] v;
    v = $urandom;
    return {v[15:4], 4'h0};
  endfunction

  task automatic acquire();
    for (int i = 0; i < 3; i++) send_frame(SYNC);
  endtask

  initial begin
    m_cyc = 0; m_anchor = 0;

    // reset mid-stream, then random bits must not strobe
    tick(1'b0, 1'b1);
    rand_bits(10);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    chk("rst_locked", locked, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    got.delete();
    rand_bits(20);
    chk("hunt_no_strobe", got.size(), 0);

    // acquisition and first payload frames
    acquire();
    send_frame(16'h1234);
    send_frame(16'hBEEF);
    send_frame(SYNC);
    chk("acq_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("acq_d0", got[0], 16'h1234);
      chk("acq_d1", got[1], 16'hBEEF);
    end
    chk("acq_locked", locked, 1);

    // timeout after 8 payload frames
    got.delete();
    for (int i = 0; i < 8; i++) send_frame(rand_data());
    tick(1'b0, 1'b0);
    chk("to_count", got.size(), 8);
    chk("to_locked", locked, 0);
    chk("to_loss", lock_loss_cnt, 1);
    rand_bits(3);

    // timeout rescue: sync on the 8th boundary keeps lock and restarts the gap
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    acquire();
    got.delete();
    for (int i = 0; i < 7; i++) send_frame(rand_data());
    send_frame(SYNC);
    for (int i = 0; i < 7; i++) send_frame(rand_data());
    send_frame(SYNC);
    chk("rescue_count", got.size(), 14);
    chk("rescue_locked", locked, 1);
    chk("rescue_loss", lock_loss_cnt, 1);

    // misaligned start
    tick(1'b0, 1'b1);
    rand_bits(5);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    got.delete();
    acquire();
    send_frame(16'h1234);
    send_frame(16'hBEEF);
    send_frame(SYNC);
    chk("mis_count", got.size(), 2);
    chk("mis_locked", locked, 1);

    // VERIFY sees a frame shifted by one bit: back to HUNT, no lock loss counted
    tick(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0);
    send_frame(SYNC);
    tick(1'b0, 1'b0);
    send_frame(SYNC);
    for (int i = 0; i < 40; i++) tick(1'b0, 1'b0);
    chk("vfail_locked", locked, 0);
    chk("vfail_loss", lock_loss_cnt, 0);

    // saturate the lock loss counter
    for (int k = 0; k < 260; k++) begin
      acquire();
      for (int i = 0; i < 8; i++) send_frame(rand_data());
    end
    tick(1'b0, 1'b0);
    chk("sat_loss", lock_loss_cnt, 255);
    chk("sat_locked", locked, 0);

    // reset while LOCKED mid-frame
    rand_bits(4);
    tick(1'b0, 1'b0); tick(1'b0, 1'b0);
    acquire();
    rand_bits(5);
    chk("pre_rst_locked", locked, 1);
    tick(1'b1, 1'b1);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_loss", lock_loss_cnt, 0);
    chk("mid_rst_valid", data_valid, 0);
    rand_bits(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
